// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, except_type bit
// positions, Status/Cause field positions and software-writable masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam int ET_SYSCALL = 8;
    localparam int ET_RI      = 9;
    localparam int ET_OV      = 10;
    localparam int ET_TRAP    = 11;
    localparam int ET_ERET    = 12;
    localparam int ET_BREAK   = 13;
    localparam int ET_ADEL    = 14;
    localparam int ET_ADES    = 15;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_BD  = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_EXC  = 2'd1,
        ACT_ERET = 2'd2
    } cp0_act_e;

    // Software write merge: only bits set in mask take the new value.
    function automatic logic [31:0] cp0_wmerge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with sticky timer interrupt; only instantiated when
// CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_HALF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);

    logic        r_phase;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        w_tick;

    // Increment qualifier: every cycle, or every second cycle in half-rate mode.
    always_comb begin
        if (COUNT_HALF != 0) begin
            w_tick = r_phase;
        end else begin
            w_tick = 1'b1;
        end
    end

    // Count, Compare and sticky interrupt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= 1'b0;
            r_count     <= 32'h0000_0000;
            r_compare   <= 32'h0000_0000;
            r_timer_int <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (w_tick) begin
                r_count <= r_count + 32'h0000_0001;
            end
            if (i_compare_we) begin
                r_compare <= i_wdata;
            end
            // A Compare write acknowledges the interrupt and beats a same-cycle match.
            if (i_compare_we) begin
                r_timer_int <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != 32'h0000_0000)) begin
                r_timer_int <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_compare   = r_compare;
    assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_commit.sv
// Write-back CP0 commit: architectural CP0 registers, precise exception /
// interrupt / ERET decision, flush and redirect. Timer optional via CP0_TIMER_EN.
module cp0_commit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter int          COUNT_HALF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cp0_reg_we,
    input  logic [4:0]  wb_cp0_reg_write_addr,
    input  logic [31:0] wb_cp0_reg_data,
    input  logic [31:0] wb_except_type,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_mem_addr,
    input  logic        wb_is_in_delayslot,
    input  logic [5:0]  int_i,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [31:0] r_badvaddr;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_int;
    logic        w_int_req;
    cp0_act_e    w_act;
    logic [4:0]  w_code;
    logic        w_mtc0_ok;
    logic [31:0] w_rd_reg;
    logic [31:0] w_rd;

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_HALF(COUNT_HALF)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_count_we  (w_mtc0_ok && (wb_cp0_reg_write_addr == CP0_COUNT)),
        .i_compare_we(w_mtc0_ok && (wb_cp0_reg_write_addr == CP0_COMPARE)),
        .i_wdata     (wb_cp0_reg_data),
        .o_count     (w_count),
        .o_compare   (w_compare),
        .o_timer_int (w_timer_int)
    );
`else
    assign w_count     = 32'h0000_0000;
    assign w_compare   = 32'h0000_0000;
    assign w_timer_int = 1'b0;
`endif

    // Interrupt qualification against the current registered Status/Cause.
    always_comb begin
        w_int_req = (wb_pc != 32'h0000_0000) && r_status[ST_IE] && !r_status[ST_EXL] &&
                    ((r_cause[15:8] & r_status[15:8]) != 8'h00);
    end

    // Priority decision: interrupt, then synchronous exceptions, then ERET.
    always_comb begin
        w_act  = ACT_NONE;
        w_code = EXC_INT;
        if (w_int_req) begin
            w_act  = ACT_EXC;
            w_code = EXC_INT;
        end else if (wb_except_type[ET_ADEL]) begin
            w_act  = ACT_EXC;
            w_code = EXC_ADEL;
        end else if (wb_except_type[ET_ADES]) begin
            w_act  = ACT_EXC;
            w_code = EXC_ADES;
        end else if (wb_except_type[ET_SYSCALL]) begin
            w_act  = ACT_EXC;
            w_code = EXC_SYS;
        end else if (wb_except_type[ET_BREAK]) begin
            w_act  = ACT_EXC;
            w_code = EXC_BP;
        end else if (wb_except_type[ET_RI]) begin
            w_act  = ACT_EXC;
            w_code = EXC_RI;
        end else if (wb_except_type[ET_OV]) begin
            w_act  = ACT_EXC;
            w_code = EXC_OV;
        end else if (wb_except_type[ET_TRAP]) begin
            w_act  = ACT_EXC;
            w_code = EXC_TR;
        end else if (wb_except_type[ET_ERET]) begin
            w_act  = ACT_ERET;
            w_code = EXC_INT;
        end else begin
            w_act  = ACT_NONE;
            w_code = EXC_INT;
        end
    end

    assign w_mtc0_ok = wb_cp0_reg_we && (w_act != ACT_EXC);

    // Same-cycle flush and redirect; silent while reset is held.
    always_comb begin
        flush_o  = 1'b0;
        new_pc_o = 32'h0000_0000;
        if (rst) begin
            flush_o  = 1'b0;
            new_pc_o = 32'h0000_0000;
        end else begin
            case (w_act)
                ACT_EXC: begin
                    flush_o  = 1'b1;
                    new_pc_o = EXC_VECTOR;
                end
                ACT_ERET: begin
                    flush_o  = 1'b1;
                    new_pc_o = r_epc;
                end
                default: begin
                    flush_o  = 1'b0;
                    new_pc_o = 32'h0000_0000;
                end
            endcase
        end
    end

    // Architectural register commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= 32'h0000_0000;
            r_status   <= STATUS_RESET;
            r_cause    <= 32'h0000_0000;
            r_epc      <= 32'h0000_0000;
        end else begin
            r_cause[15]    <= int_i[5] | w_timer_int;
            r_cause[14:10] <= int_i[4:0];
            case (w_act)
                ACT_EXC: begin
                    // A nested exception keeps the original return point.
                    if (!r_status[ST_EXL]) begin
                        r_epc          <= wb_is_in_delayslot ? (wb_pc - 32'h0000_0004) : wb_pc;
                        r_cause[CA_BD] <= wb_is_in_delayslot;
                    end
                    r_status[ST_EXL] <= 1'b1;
                    r_cause[6:2]     <= w_code;
                    if ((w_code == EXC_ADEL) || (w_code == EXC_ADES)) begin
                        r_badvaddr <= wb_mem_addr;
                    end
                end
                default: begin
                    if (wb_cp0_reg_we) begin
                        case (wb_cp0_reg_write_addr)
                            CP0_STATUS: r_status   <= cp0_wmerge(r_status, wb_cp0_reg_data, STATUS_WMASK);
                            CP0_CAUSE:  r_cause[9:8] <= wb_cp0_reg_data[9:8];
                            CP0_EPC:    r_epc      <= wb_cp0_reg_data;
                            default:    ;
                        endcase
                    end
                    if (w_act == ACT_ERET) begin
                        r_status[ST_EXL] <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Registered-state read mux.
    always_comb begin
        case (raddr)
            CP0_BADVADDR: w_rd_reg = r_badvaddr;
            CP0_COUNT:    w_rd_reg = w_count;
            CP0_COMPARE:  w_rd_reg = w_compare;
            CP0_STATUS:   w_rd_reg = r_status;
            CP0_CAUSE:    w_rd_reg = r_cause;
            CP0_EPC:      w_rd_reg = r_epc;
            CP0_PRID:     w_rd_reg = PRID_VALUE;
            default:      w_rd_reg = 32'h0000_0000;
        endcase
    end

    // Forward a committing MTC0 so a same-cycle MFC0 sees the new value.
    always_comb begin
        w_rd = w_rd_reg;
        if (w_mtc0_ok && (raddr == wb_cp0_reg_write_addr)) begin
            case (raddr)
                CP0_STATUS: w_rd = cp0_wmerge(r_status, wb_cp0_reg_data, STATUS_WMASK);
                CP0_CAUSE:  w_rd = cp0_wmerge(r_cause, wb_cp0_reg_data, CAUSE_WMASK);
                CP0_EPC:    w_rd = wb_cp0_reg_data;
`ifdef CP0_TIMER_EN
                CP0_COUNT:   w_rd = wb_cp0_reg_data;
                CP0_COMPARE: w_rd = wb_cp0_reg_data;
`endif
                default:    w_rd = w_rd_reg;
            endcase
        end else begin
            w_rd = w_rd_reg;
        end
    end

    assign rdata       = w_rd;
    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = w_timer_int;

endmodule

// File: tb/tb_cp0_commit.sv
// Scoreboard bench for cp0_commit: directed steps push expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares.
module tb_cp0_commit;

    localparam int S_RDATA  = 0;
    localparam int S_STATUS = 1;
    localparam int S_CAUSE  = 2;
    localparam int S_EPC    = 3;
    localparam int S_FLUSH  = 4;
    localparam int S_NEWPC  = 5;
    localparam int S_TIMER  = 6;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_write_addr;
    logic [31:0] wb_cp0_reg_data;
    logic [31:0] wb_except_type;
    logic [31:0] wb_pc;
    logic [31:0] wb_mem_addr;
    logic        wb_is_in_delayslot;
    logic [5:0]  int_i;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        timer_int_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    cp0_commit #(
        .EXC_VECTOR(32'hBFC0_0380),
        .PRID_VALUE(32'h0000_4220),
        .COUNT_HALF(1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wb_cp0_reg_we        (wb_cp0_reg_we),
        .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr),
        .wb_cp0_reg_data      (wb_cp0_reg_data),
        .wb_except_type       (wb_except_type),
        .wb_pc                (wb_pc),
        .wb_mem_addr          (wb_mem_addr),
        .wb_is_in_delayslot   (wb_is_in_delayslot),
        .int_i                (int_i),
        .raddr                (raddr),
        .rdata                (rdata),
        .status_o             (status_o),
        .cause_o              (cause_o),
        .epc_o                (epc_o),
        .timer_int_o          (timer_int_o),
        .flush_o              (flush_o),
        .new_pc_o             (new_pc_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sel_val(input int s);
        case (s)
            S_RDATA:  return rdata;
            S_STATUS: return status_o;
            S_CAUSE:  return cause_o;
            S_EPC:    return epc_o;
            S_FLUSH:  return {31'h0, flush_o};
            S_NEWPC:  return new_pc_o;
            S_TIMER:  return {31'h0, timer_int_o};
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = q.pop_front();
            act = sel_val(e.sel);
            n_cmp = n_cmp + 1;
            if (act !== e.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %08h expected %08h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic exp_now(input int s, input logic [31:0] v, input string nm);
        q.push_back('{cyc, s, v, nm});
    endtask

    task automatic exp_next(input int s, input logic [31:0] v, input string nm);
        q.push_back('{cyc + 1, s, v, nm});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] exc, input logic [31:0] pc, input logic [31:0] ma,
                       input logic ds, input logic [4:0] ra);
        wb_cp0_reg_we         = we;
        wb_cp0_reg_write_addr = wa;
        wb_cp0_reg_data       = wd;
        wb_except_type        = exc;
        wb_pc                 = pc;
        wb_mem_addr           = ma;
        wb_is_in_delayslot    = ds;
        raddr                 = ra;
    endtask

    task automatic idle(input logic [4:0] ra);
        drv(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, ra);
    endtask

    initial begin
        int  k;
        bit  seen;
        rst   = 1'b1;
        int_i = 6'd0;
        idle(5'd0);
        repeat (2) tick();

        // Reset held with an exception on the inputs: no flush.
        drv(1'b0, 5'd0, 32'h0, 32'h0000_0100, 32'h8000_0000, 32'h0, 1'b0, 5'd0);
        exp_now(S_FLUSH, 32'h0, "rst_flush");
        exp_now(S_NEWPC, 32'h0, "rst_newpc");
        tick();
        rst = 1'b0;
        idle(5'd15);
        exp_now(S_RDATA, 32'h0000_4220, "prid");
        exp_now(S_STATUS, 32'h0040_0000, "rst_status");
        exp_now(S_CAUSE, 32'h0, "rst_cause");
        exp_now(S_EPC, 32'h0, "rst_epc");
        exp_now(S_TIMER, 32'h0, "rst_timer");
        exp_now(S_FLUSH, 32'h0, "idle_flush");
        tick();
        idle(5'd8);
        exp_now(S_RDATA, 32'h0, "rst_badvaddr");
        tick();

        // MTC0 Status all ones: only IM/EXL/IE take, bypassed to rdata.
        drv(1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0, 5'd12);
        exp_now(S_RDATA, 32'h0040_FF03, "status_bypass");
        exp_now(S_STATUS, 32'h0040_0000, "status_before_edge");
        exp_now(S_NEWPC, 32'h0, "mtc0_newpc");
        exp_next(S_STATUS, 32'h0040_FF03, "status_write");
        tick();
        drv(1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd12);
        exp_now(S_RDATA, 32'h0040_0000, "status_clr_bypass");
        exp_next(S_STATUS, 32'h0040_0000, "status_clr");
        tick();

        // Delay-slot SYSCALL.
        drv(1'b0, 5'd0, 32'h0, 32'h0000_0100, 32'h8000_0104, 32'h0, 1'b1, 5'd0);
        exp_now(S_FLUSH, 32'h1, "sys_flush");
        exp_now(S_NEWPC, VEC, "sys_newpc");
        exp_next(S_EPC, 32'h8000_0100, "sys_epc");
        exp_next(S_CAUSE, 32'h8000_0020, "sys_cause");
        exp_next(S_STATUS, 32'h0040_0002, "sys_exl");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0200, 32'h0, 1'b0, 5'd0);
        exp_now(S_FLUSH, 32'h1, "eret_flush");
        exp_now(S_NEWPC, 32'h8000_0100, "eret_newpc");
        exp_next(S_STATUS, 32'h0040_0000, "eret_exl");
        tick();

        // AdES with faulting address.
        drv(1'b0, 5'd0, 32'h0, 32'h0000_8000, 32'h8000_0300, 32'h1234_5671, 1'b0, 5'd0);
        exp_now(S_NEWPC, VEC, "ades_newpc");
        exp_next(S_EPC, 32'h8000_0300, "ades_epc");
        exp_next(S_CAUSE, 32'h0000_0014, "ades_cause");
        tick();
        idle(5'd8);
        exp_now(S_RDATA, 32'h1234_5671, "ades_badvaddr");
        tick();

        // Nested RI with EXL=1: EPC and BD untouched.
        drv(1'b0, 5'd0, 32'h0, 32'h0000_0200, 32'h8000_0500, 32'h0, 1'b1, 5'd0);
        exp_now(S_FLUSH, 32'h1, "ri_flush");
        exp_next(S_EPC, 32'h8000_0300, "ri_epc_kept");
        exp_next(S_CAUSE, 32'h0000_0028, "ri_cause");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0510, 32'h0, 1'b0, 5'd0);
        exp_now(S_NEWPC, 32'h8000_0300, "eret2_newpc");
        exp_next(S_STATUS, 32'h0040_0000, "eret2_exl");
        tick();

        // MTC0 EPC together with Ov: write dropped, no bypass.
        drv(1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_0400, 32'h8000_0600, 32'h0, 1'b0, 5'd14);
        exp_now(S_RDATA, 32'h8000_0300, "ov_no_bypass");
        exp_now(S_NEWPC, VEC, "ov_newpc");
        exp_next(S_EPC, 32'h8000_0600, "ov_epc");
        exp_next(S_CAUSE, 32'h0000_0030, "ov_cause");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0610, 32'h0, 1'b0, 5'd0);
        exp_now(S_NEWPC, 32'h8000_0600, "eret3_newpc");
        tick();

        // AdEL beats SYSCALL and Ov.
        drv(1'b0, 5'd0, 32'h0, 32'h0000_4500, 32'h8000_0700, 32'h0000_0ABC, 1'b0, 5'd0);
        exp_next(S_CAUSE, 32'h0000_0010, "prio_cause");
        exp_next(S_EPC, 32'h8000_0700, "prio_epc");
        tick();
        idle(5'd8);
        exp_now(S_RDATA, 32'h0000_0ABC, "adel_badvaddr");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0710, 32'h0, 1'b0, 5'd0);
        exp_next(S_STATUS, 32'h0040_0000, "eret4_exl");
        tick();

        // Software interrupt IP0 with IM0/IE.
        drv(1'b1, 5'd12, 32'h0000_0101, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        exp_next(S_STATUS, 32'h0040_0101, "status_im0");
        tick();
        drv(1'b1, 5'd13, 32'hFFFF_FDFF, 32'h0, 32'h0, 32'h0, 1'b0, 5'd13);
        exp_now(S_RDATA, 32'h0000_0110, "cause_bypass");
        exp_next(S_CAUSE, 32'h0000_0110, "cause_write_mask");
        tick();
        idle(5'd0);
        exp_now(S_FLUSH, 32'h0, "bubble_no_int");
        exp_now(S_NEWPC, 32'h0, "bubble_newpc");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_0100, 32'h8000_0800, 32'h0, 1'b0, 5'd0);
        exp_now(S_FLUSH, 32'h1, "int_flush");
        exp_now(S_NEWPC, VEC, "int_newpc");
        exp_next(S_CAUSE, 32'h0000_0100, "int_cause");
        exp_next(S_EPC, 32'h8000_0800, "int_epc");
        exp_next(S_STATUS, 32'h0040_0103, "int_status");
        tick();
        drv(1'b1, 5'd13, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        exp_next(S_CAUSE, 32'h0, "cause_clear");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0810, 32'h0, 1'b0, 5'd0);
        exp_now(S_NEWPC, 32'h8000_0800, "eret5_newpc");
        exp_next(S_STATUS, 32'h0040_0101, "eret5_status");
        tick();

        // External interrupt lines sampled into Cause.IP.
        int_i = 6'b100100;
        idle(5'd0);
        exp_next(S_CAUSE, 32'h0000_9000, "hw_ip");
        tick();
        int_i = 6'd0;
        exp_next(S_CAUSE, 32'h0, "hw_ip_clear");
        tick();

`ifdef CP0_TIMER_EN
        drv(1'b1, 5'd12, 32'h0000_8001, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        exp_next(S_STATUS, 32'h0040_8001, "status_im7");
        tick();
        drv(1'b1, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick();
        drv(1'b1, 5'd11, 32'h0000_000A, 32'h0, 32'h0, 32'h0, 1'b0, 5'd11);
        exp_now(S_RDATA, 32'h0000_000A, "compare_bypass");
        exp_now(S_TIMER, 32'h0, "timer_low");
        seen = 1'b0;
        k    = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            idle(5'd0);
            if (!seen && timer_int_o) begin
                seen = 1'b1;
                k    = i;
                break;
            end
        end
        n_cmp = n_cmp + 1;
        if (!seen || k < 18 || k > 23) begin
            n_fail = n_fail + 1;
            $display("FAIL timer_latency: got %0d cycles (seen=%0d) expected 18..23", k, seen);
        end
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0, 32'h8000_0A00, 32'h0, 1'b0, 5'd0);
        exp_now(S_FLUSH, 32'h1, "timer_int_flush");
        exp_now(S_NEWPC, VEC, "timer_int_newpc");
        exp_next(S_CAUSE, 32'h0000_8000, "timer_int_cause");
        exp_next(S_EPC, 32'h8000_0A00, "timer_int_epc");
        tick();
        drv(1'b1, 5'd11, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        exp_now(S_TIMER, 32'h1, "timer_sticky");
        exp_next(S_TIMER, 32'h0, "timer_cleared");
        tick();
        idle(5'd0);
        exp_next(S_CAUSE, 32'h0, "timer_ip_clear");
        tick();
        drv(1'b0, 5'd0, 32'h0, 32'h0000_1000, 32'h8000_0A10, 32'h0, 1'b0, 5'd0);
        exp_now(S_NEWPC, 32'h8000_0A00, "eret6_newpc");
        exp_next(S_STATUS, 32'h0040_8001, "eret6_status");
        tick();
`else
        drv(1'b1, 5'd9, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b0, 5'd9);
        exp_now(S_RDATA, 32'h0, "count_absent_bypass");
        tick();
        drv(1'b1, 5'd11, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 1'b0, 5'd11);
        exp_now(S_RDATA, 32'h0, "compare_absent_bypass");
        tick();
        idle(5'd9);
        exp_now(S_RDATA, 32'h0, "count_absent");
        exp_now(S_TIMER, 32'h0, "timer_absent");
        tick();
`endif

        // Reset mid-operation.
        rst = 1'b1;
        drv(1'b0, 5'd0, 32'h0, 32'h0000_0100, 32'h8000_0B00, 32'h0, 1'b0, 5'd0);
        exp_now(S_FLUSH, 32'h0, "midrst_flush");
        exp_now(S_NEWPC, 32'h0, "midrst_newpc");
        exp_next(S_STATUS, 32'h0040_0000, "midrst_status");
        exp_next(S_EPC, 32'h0, "midrst_epc");
        exp_next(S_CAUSE, 32'h0, "midrst_cause");
        exp_next(S_TIMER, 32'h0, "midrst_timer");
        tick();
        rst = 1'b0;
        idle(5'd0);

        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: never sampled (due cycle %0d)", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
